spm_port_arbiter: RTL and testbench

//  Serialises the two BRAM-style ports (port 0, port 1) of an HLS accelerator core onto one

---
 rtl/spm_port_arbiter_if.sv | 30 +++
 rtl/spm_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_spm_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_port_arbiter_if.sv
// Memory-channel bundle between spm_port_arbiter and the host read/write channel.
//   master modport : arbiter side (drives request, receives read response)
//   slave modport  : memory/host side (accepts request, returns read data)
// Signals:
//   mem_req_valid / mem_req_ready : request handshake, accepted on valid&ready at posedge
//   mem_req_we                    : 1 = write, 0 = read
//   mem_req_addr                  : 64-bit byte address
//   mem_req_wdata                 : write data
//   mem_rsp_valid / mem_rsp_data  : in-order read response, one per read
interface spm_port_arbiter_if #(
  parameter int DATA_WID = 32
) ();
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [63:0]         mem_req_addr;
  logic [DATA_WID-1:0] mem_req_wdata;
  logic                mem_rsp_valid;
  logic [DATA_WID-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter
// Serialises the two BRAM-style ports of an HLS core onto a single external
// memory channel. One request is in flight at a time and at most one read is
// outstanding; the core is stalled while its batch of accesses completes.
// Ports:
//   mod_clk, reset        : core clock, asynchronous active-high reset
//   rd_base, wr_base      : byte bases for reads / writes (static while busy)
//   addr*/ce*/we*/d*      : core port 0/1 address, enable, write enable, write data
//   q0, q1                : registered read data per port
//   stall                 : high while a batch is being serviced
//   mem                   : memory channel (spm_port_arbiter_if.master)
//   access_cnt, stall_cnt : accepted requests / stalled cycles, wrapping
//   rsp_err               : sticky, read response seen while not waiting for one
module spm_port_arbiter #(
  parameter int ADDR_WID = 13,
  parameter int DATA_WID = 32,
  parameter int RR_ORDER = 0
) (
  input  logic                mod_clk,
  input  logic                reset,
  input  logic [63:0]         rd_base,
  input  logic [63:0]         wr_base,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic                ce0,
  input  logic                ce1,
  input  logic                we0,
  input  logic                we1,
  input  logic [DATA_WID-1:0] d0,
  input  logic [DATA_WID-1:0] d1,
  output logic [DATA_WID-1:0] q0,
  output logic [DATA_WID-1:0] q1,
  output logic                stall,
  spm_port_arbiter_if.master  mem,
  output logic [31:0]         access_cnt,
  output logic [31:0]         stall_cnt,
  output logic                rsp_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam bit RR_EN = (RR_ORDER != 32'sd0);

  // Zero-extended word address scaled to bytes; the add wraps modulo 2^64.
  function automatic logic [63:0] byte_addr(input logic [63:0] base,
                                            input logic [ADDR_WID-1:0] a);
    logic [63:0] ext;
    ext = {{(64-ADDR_WID){1'b0}}, a};
    return base + (ext << 3'd2);
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [1:0]                 pend_q, pend_d;     // per-port slot still to be served
  logic                       cur_q, cur_d;       // port currently being served
  logic                       rr_q, rr_d;         // first port of the next two-port batch
  logic [1:0][ADDR_WID-1:0]   p_addr_q, p_addr_d;
  logic [1:0]                 p_we_q, p_we_d;
  logic [1:0][DATA_WID-1:0]   p_d_q, p_d_d;
  logic [1:0][DATA_WID-1:0]   q_q, q_d;
  logic                       req_valid_q, req_valid_d;
  logic                       req_we_q, req_we_d;
  logic [63:0]                req_addr_q, req_addr_d;
  logic [DATA_WID-1:0]        req_wdata_q, req_wdata_d;
  logic [31:0]                access_cnt_q, access_cnt_d;
  logic [31:0]                stall_cnt_q, stall_cnt_d;
  logic                       rsp_err_q, rsp_err_d;

  logic done_s;   // current slot finished this cycle
  logic first_s;  // port served first in a newly captured batch
  logic nxt_s;    // the other port, candidate for the next slot

  // Next-state, slot capture and request payload computation.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cur_d        = cur_q;
    rr_d         = rr_q;
    p_addr_d     = p_addr_q;
    p_we_d       = p_we_q;
    p_d_d        = p_d_q;
    q_d          = q_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    access_cnt_d = access_cnt_q;
    stall_cnt_d  = (state_q != ST_IDLE) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    rsp_err_d    = rsp_err_q | (mem.mem_rsp_valid & (state_q != ST_WAIT));
    done_s       = 1'b0;
    first_s      = 1'b0;
    nxt_s        = ~cur_q;

    case (state_q)
      ST_IDLE: begin
        if (ce0 | ce1) begin
          pend_d      = {ce1, ce0};
          p_addr_d[0] = ce0 ? addr0 : p_addr_q[0];
          p_we_d[0]   = ce0 ? we0   : p_we_q[0];
          p_d_d[0]    = ce0 ? d0    : p_d_q[0];
          p_addr_d[1] = ce1 ? addr1 : p_addr_q[1];
          p_we_d[1]   = ce1 ? we1   : p_we_q[1];
          p_d_d[1]    = ce1 ? d1    : p_d_q[1];
          if (ce0 & ce1) begin
            first_s = rr_q;
            rr_d    = RR_EN ? ~rr_q : rr_q;
          end else begin
            // Single-port batch: ce1 alone means port 1.
            first_s = ce1;
            rr_d    = rr_q;
          end
          // The first request is built straight from the port inputs, which
          // are being captured on this same edge.
          cur_d       = first_s;
          req_we_d    = first_s ? we1 : we0;
          req_addr_d  = byte_addr(req_we_d ? wr_base : rd_base, first_s ? addr1 : addr0);
          req_wdata_d = first_s ? d1 : d0;
          req_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem.mem_req_ready) begin
          access_cnt_d = access_cnt_q + 32'd1;
          if (req_we_q) begin
            // Writes are posted: the slot is complete at acceptance.
            done_s = 1'b1;
          end else begin
            req_valid_d = 1'b0;
            state_d     = ST_WAIT;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rsp_valid) begin
          q_d[cur_q] = mem.mem_rsp_data;
          done_s     = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    // Retire the current slot and move on to the other port if it is pending.
    if (done_s) begin
      pend_d[cur_q] = 1'b0;
      if (pend_q[nxt_s]) begin
        cur_d       = nxt_s;
        req_valid_d = 1'b1;
        req_we_d    = p_we_q[nxt_s];
        req_addr_d  = byte_addr(p_we_q[nxt_s] ? wr_base : rd_base, p_addr_q[nxt_s]);
        req_wdata_d = p_d_q[nxt_s];
        state_d     = ST_ISSUE;
      end else begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    end else begin
      nxt_s = ~cur_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_q       <= 2'b00;
      cur_q        <= 1'b0;
      rr_q         <= 1'b0;
      p_addr_q     <= '0;
      p_we_q       <= 2'b00;
      p_d_q        <= '0;
      q_q          <= '0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= 64'd0;
      req_wdata_q  <= '0;
      access_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cur_q        <= cur_d;
      rr_q         <= rr_d;
      p_addr_q     <= p_addr_d;
      p_we_q       <= p_we_d;
      p_d_q        <= p_d_d;
      q_q          <= q_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      access_cnt_q <= access_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign stall             = (state_q != ST_IDLE);
  assign q0                = q_q[0];
  assign q1                = q_q[1];
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign access_cnt        = access_cnt_q;
  assign stall_cnt         = stall_cnt_q;
  assign rsp_err           = rsp_err_q;

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed testbench for spm_port_arbiter with a small memory responder.
module tb_spm_port_arbiter;

  logic        mod_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [63:0] rd_base, wr_base;
  logic [12:0] addr0, addr1;
  logic        ce0, ce1, we0, we1;
  logic [31:0] d0, d1, q0, q1;
  logic        stall;
  logic [31:0] access_cnt, stall_cnt;
  logic        rsp_err;

  always #5 mod_clk = ~mod_clk;

  spm_port_arbiter_if #(.DATA_WID(32)) bus ();

  spm_port_arbiter #(.ADDR_WID(13), .DATA_WID(32), .RR_ORDER(1)) dut (
    .mod_clk    (mod_clk),
    .reset      (reset),
    .rd_base    (rd_base),
    .wr_base    (wr_base),
    .addr0      (addr0),
    .addr1      (addr1),
    .ce0        (ce0),
    .ce1        (ce1),
    .we0        (we0),
    .we1        (we1),
    .d0         (d0),
    .d1         (d1),
    .q0         (q0),
    .q1         (q1),
    .stall      (stall),
    .mem        (bus),
    .access_cnt (access_cnt),
    .stall_cnt  (stall_cnt),
    .rsp_err    (rsp_err)
  );

  // Memory model and request log
  logic [31:0] mem_m [logic [63:0]];
  logic [63:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];
  logic        auto_rsp = 1'b1;
  logic        inj_rsp  = 1'b0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_dat  = 32'd0;

  int total = 0;
  int bad   = 0;

  // Responder: sees accepted requests at negedge, answers reads one cycle later.
  always @(negedge mod_clk) begin
    bus.mem_rsp_valid = rsp_pend | inj_rsp;
    bus.mem_rsp_data  = rsp_dat;
    rsp_pend = 1'b0;
    if (!reset && bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
      log_addr.push_back(bus.mem_req_addr);
      log_we.push_back(bus.mem_req_we);
      log_wd.push_back(bus.mem_req_wdata);
      if (bus.mem_req_we) begin
        mem_m[bus.mem_req_addr] = bus.mem_req_wdata;
      end else if (auto_rsp) begin
        rsp_pend = 1'b1;
        rsp_dat  = mem_m.exists(bus.mem_req_addr) ? mem_m[bus.mem_req_addr] : 32'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] la(input int i);
    return (log_addr.size() > i) ? log_addr[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] lw(input int i);
    return (log_we.size() > i) ? {63'd0, log_we[i]} : 64'hDEAD;
  endfunction

  function automatic logic [63:0] ld(input int i);
    return (log_wd.size() > i) ? {32'd0, log_wd[i]} : 64'hDEAD;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ce0 = 1'b0;
    ce1 = 1'b0;
    @(negedge mod_clk);
    @(negedge mod_clk);
    reset = 1'b0;
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
    @(negedge mod_clk);
  endtask

  // Presents one batch at a negedge and counts stalled cycles until idle.
  task automatic batch(input logic c0, input logic w0, input logic [12:0] a0, input logic [31:0] dd0,
                       input logic c1, input logic w1, input logic [12:0] a1, input logic [31:0] dd1,
                       output int n);
    ce0 = c0; we0 = w0; addr0 = a0; d0 = dd0;
    ce1 = c1; we1 = w1; addr1 = a1; d1 = dd1;
    @(negedge mod_clk);
    ce0 = 1'b0;
    ce1 = 1'b0;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge mod_clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rd_base = 64'd0; wr_base = 64'd0;
    addr0 = 13'd0; addr1 = 13'd0;
    ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    d0 = 32'd0; d1 = 32'd0;
    bus.mem_req_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge mod_clk);

    // Reset state
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    chk("rst_q0", {32'd0, q0}, 64'd0);
    chk("rst_q1", {32'd0, q1}, 64'd0);
    chk("rst_acc", {32'd0, access_cnt}, 64'd0);
    chk("rst_scnt", {32'd0, stall_cnt}, 64'd0);
    chk("rst_err", {63'd0, rsp_err}, 64'd0);
    reset = 1'b0;
    @(negedge mod_clk);

    // T1: single read on port 0
    rd_base = 64'h1000;
    mem_m[64'h1014] = 32'hAB;
    batch(1'b1, 1'b0, 13'd5, 32'd0, 1'b0, 1'b0, 13'd0, 32'd0, n);
    chk("t1_stall", n, 64'd2);
    chk("t1_nreq", log_addr.size(), 64'd1);
    chk("t1_addr", la(0), 64'h1014);
    chk("t1_we", lw(0), 64'd0);
    chk("t1_q0", {32'd0, q0}, 64'hAB);
    chk("t1_q1", {32'd0, q1}, 64'd0);
    chk("t1_acc", {32'd0, access_cnt}, 64'd1);
    chk("t1_scnt", {32'd0, stall_cnt}, 64'd2);
    chk("t1_err", {63'd0, rsp_err}, 64'd0);

    // T2: write on port 0 then read of the same word on port 1
    do_reset();
    rd_base = 64'd0; wr_base = 64'd0;
    batch(1'b1, 1'b1, 13'd3, 32'd7, 1'b1, 1'b0, 13'd3, 32'd0, n);
    chk("t2_stall", n, 64'd3);
    chk("t2_a0", la(0), 64'hC);
    chk("t2_we0", lw(0), 64'd1);
    chk("t2_wd0", ld(0), 64'd7);
    chk("t2_a1", la(1), 64'hC);
    chk("t2_we1", lw(1), 64'd0);
    chk("t2_q1", {32'd0, q1}, 64'd7);
    chk("t2_q0", {32'd0, q0}, 64'd0);
    chk("t2_acc", {32'd0, access_cnt}, 64'd2);
    chk("t2_scnt", {32'd0, stall_cnt}, 64'd3);

    // T3: request held for 10 cycles of ready low
    do_reset();
    wr_base = 64'h2000;
    bus.mem_req_ready = 1'b0;
    ce1 = 1'b1; we1 = 1'b1; addr1 = 13'd2; d1 = 32'h55;
    @(negedge mod_clk);
    ce1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", {63'd0, bus.mem_req_valid}, 64'd1);
      chk("t3_addr", bus.mem_req_addr, 64'h2008);
      chk("t3_wdata", {32'd0, bus.mem_req_wdata}, 64'h55);
      if (i < 9) begin
        @(negedge mod_clk);
      end else begin
        @(posedge mod_clk);
        #1 bus.mem_req_ready = 1'b1;
        @(negedge mod_clk);
      end
    end
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge mod_clk);
    end
    chk("t3_tail", n, 64'd1);
    chk("t3_scnt", {32'd0, stall_cnt}, 64'd11);
    chk("t3_acc", {32'd0, access_cnt}, 64'd1);
    chk("t3_mem", {32'd0, mem_m.exists(64'h2008) ? mem_m[64'h2008] : 32'd0}, 64'h55);

    // T4: round-robin first port over three two-port batches
    do_reset();
    rd_base = 64'd0;
    mem_m[64'h40] = 32'h1111;
    mem_m[64'h80] = 32'h2222;
    for (int b = 0; b < 3; b++) begin
      batch(1'b1, 1'b0, 13'd16, 32'd0, 1'b1, 1'b0, 13'd32, 32'd0, n);
      chk("t4_stall", n, 64'd4);
    end
    chk("t4_first0", la(0), 64'h40);
    chk("t4_second0", la(1), 64'h80);
    chk("t4_first1", la(2), 64'h80);
    chk("t4_first2", la(4), 64'h40);
    chk("t4_q0", {32'd0, q0}, 64'h1111);
    chk("t4_q1", {32'd0, q1}, 64'h2222);
    chk("t4_acc", {32'd0, access_cnt}, 64'd6);

    // T5: reset while waiting for a read response, then a stray response
    auto_rsp = 1'b0;
    ce0 = 1'b1; we0 = 1'b0; addr0 = 13'd1;
    @(negedge mod_clk);
    ce0 = 1'b0;
    @(negedge mod_clk);
    chk("t5_pre_stall", {63'd0, stall}, 64'd1);
    chk("t5_pre_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    reset = 1'b1;
    #1;
    chk("t5_stall", {63'd0, stall}, 64'd0);
    chk("t5_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    chk("t5_q0", {32'd0, q0}, 64'd0);
    chk("t5_q1", {32'd0, q1}, 64'd0);
    chk("t5_acc", {32'd0, access_cnt}, 64'd0);
    chk("t5_scnt", {32'd0, stall_cnt}, 64'd0);
    @(negedge mod_clk);
    reset = 1'b0;
    @(negedge mod_clk);
    chk("t5_err_pre", {63'd0, rsp_err}, 64'd0);
    inj_rsp = 1'b1;
    @(negedge mod_clk);
    @(negedge mod_clk);
    inj_rsp = 1'b0;
    @(negedge mod_clk);
    @(negedge mod_clk);
    chk("t5_err", {63'd0, rsp_err}, 64'd1);
    chk("t5_idle", {63'd0, stall}, 64'd0);
    auto_rsp = 1'b1;

    // T6: address wraps modulo 2^64
    do_reset();
    rd_base = 64'hFFFF_FFFF_FFFF_FFF0;
    batch(1'b1, 1'b0, 13'd8191, 32'd0, 1'b0, 1'b0, 13'd0, 32'd0, n);
    chk("t6_addr", la(0), 64'h7FEC);
    chk("t6_stall", n, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
